// File: rtl/dl11_pkg.sv
// Shared constants and state types for the DL11 console host register block.
package dl11_pkg;

  localparam logic [2:0] RcsrOff = 3'd0;
  localparam logic [2:0] RbufOff = 3'd2;
  localparam logic [2:0] XcsrOff = 3'd4;
  localparam logic [2:0] XbufOff = 3'd6;

  localparam int unsigned DoneBit = 7;
  localparam int unsigned IeBit   = 6;
  localparam int unsigned ErrBit  = 15;
  localparam int unsigned OvrBit  = 14;

  typedef enum logic [1:0] {RxIdle, RxReq, RxRel} rx_state_t;
  typedef enum logic [1:0] {TxIdle, TxReq, TxRel, TxDrain} tx_state_t;

  function automatic logic [2:0] reg_off(input logic [1:0] sel);
    return {sel, 1'b0};
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one level signal arriving from the uart clock domain.
module sync_bit #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/dl11_host.sv
// DL11 console register block driving the uart load/unload 4-phase handshakes.
// Optional RBUF OVERRUN/ERR flags are built when DL11_RBUF_ERR_EN is defined.
module dl11_host
  import dl11_pkg::*;
#(
  parameter logic [12:0] BaseAddr   = 13'o17560,
  parameter int unsigned SyncStages = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [12:0] bus_addr_i,
  input  logic        bus_rd_i,
  input  logic        bus_wr_i,
  input  logic [15:0] bus_wdata_i,
  output logic [15:0] bus_rdata_o,
  output logic        bus_hit_o,
  output logic        rx_int_o,
  output logic        tx_int_o,
  output logic        ld_tx_req_o,
  input  logic        ld_tx_ack_i,
  output logic [7:0]  tx_data_o,
  input  logic        tx_empty_i,
  output logic        uld_rx_req_o,
  input  logic        uld_rx_ack_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_empty_i
);

  logic tx_ack_s, tx_empty_s, rx_ack_s, rx_empty_s;

  // Acks reset high so a handshake left open by a reset must visibly close before re-arming.
  sync_bit #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_tx_ack (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(ld_tx_ack_i), .q_o(tx_ack_s));
  sync_bit #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_tx_empty (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(tx_empty_i), .q_o(tx_empty_s));
  sync_bit #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_rx_ack (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(uld_rx_ack_i), .q_o(rx_ack_s));
  sync_bit #(.Stages(SyncStages), .ResetVal(1'b1)) u_sync_rx_empty (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(rx_empty_i), .q_o(rx_empty_s));

  rx_state_t   rx_state_q, rx_state_d;
  tx_state_t   tx_state_q, tx_state_d;
  logic        uld_rx_req_q, uld_rx_req_d, ld_tx_req_q, ld_tx_req_d;
  logic        done_q, rx_ie_q, ready_q, ready_d, tx_ie_q;
  logic [7:0]  rbuf_q, tx_data_q, tx_data_d;
  logic [15:0] bus_rdata_q, rdata_mux;
  logic        bus_hit_q, rx_capture, rbuf_err, rbuf_ovr;

  logic       addr_hit, rd_hit, wr_hit, rbuf_rd, tx_accept;
  logic [2:0] off;
  logic       unused_bits;

  assign addr_hit  = (bus_addr_i[12:3] == BaseAddr[12:3]);
  assign off       = reg_off(bus_addr_i[2:1]);
  assign rd_hit    = bus_rd_i & addr_hit;
  assign wr_hit    = bus_wr_i & addr_hit;
  assign rbuf_rd   = rd_hit & (off == RbufOff);
  // READY is sampled pre-update, so a write coinciding with READY rising is dropped.
  assign tx_accept = wr_hit & (off == XbufOff) & ready_q;
  assign unused_bits = ^{bus_addr_i[0], bus_wdata_i[15:8]};

  always_comb begin
    rx_state_d   = rx_state_q;
    uld_rx_req_d = uld_rx_req_q;
    rx_capture   = 1'b0;
    unique case (rx_state_q)
      RxIdle: if (!rx_empty_s && !rx_ack_s) begin
        rx_state_d   = RxReq;
        uld_rx_req_d = 1'b1;
      end
      RxReq: if (rx_ack_s) begin
        rx_state_d   = RxRel;
        uld_rx_req_d = 1'b0;
        rx_capture   = 1'b1;
      end
      RxRel: if (!rx_ack_s) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    ld_tx_req_d = ld_tx_req_q;
    ready_d     = ready_q;
    tx_data_d   = tx_data_q;
    unique case (tx_state_q)
      TxIdle: if (tx_accept) begin
        tx_state_d  = TxReq;
        ld_tx_req_d = 1'b1;
        ready_d     = 1'b0;
        tx_data_d   = bus_wdata_i[7:0];
      end
      TxReq: if (tx_ack_s) begin
        tx_state_d  = TxRel;
        ld_tx_req_d = 1'b0;
      end
      TxRel:   if (!tx_ack_s) tx_state_d = TxDrain;
      TxDrain: if (tx_empty_s) begin
        tx_state_d = TxIdle;
        ready_d    = 1'b1;
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    unique case (off)
      RcsrOff: begin
        rdata_mux[DoneBit] = done_q;
        rdata_mux[IeBit]   = rx_ie_q;
      end
      RbufOff: begin
        rdata_mux[7:0]    = rbuf_q;
        rdata_mux[ErrBit] = rbuf_err;
        rdata_mux[OvrBit] = rbuf_ovr;
      end
      XcsrOff: begin
        rdata_mux[DoneBit] = ready_q;
        rdata_mux[IeBit]   = tx_ie_q;
      end
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q   <= RxIdle;
      tx_state_q   <= TxIdle;
      uld_rx_req_q <= 1'b0;
      ld_tx_req_q  <= 1'b0;
      ready_q      <= 1'b1;
      tx_data_q    <= '0;
      done_q       <= 1'b0;
      rbuf_q       <= '0;
      rx_ie_q      <= 1'b0;
      tx_ie_q      <= 1'b0;
      bus_rdata_q  <= '0;
      bus_hit_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      uld_rx_req_q <= uld_rx_req_d;
      ld_tx_req_q  <= ld_tx_req_d;
      ready_q      <= ready_d;
      tx_data_q    <= tx_data_d;
      // Capture outranks the clear-on-read of DONE.
      if (rx_capture) begin
        rbuf_q <= rx_data_i;
        done_q <= 1'b1;
      end else if (rbuf_rd) begin
        done_q <= 1'b0;
      end
      if (wr_hit && off == RcsrOff) rx_ie_q <= bus_wdata_i[IeBit];
      if (wr_hit && off == XcsrOff) tx_ie_q <= bus_wdata_i[IeBit];
      if (bus_rd_i) bus_rdata_q <= addr_hit ? rdata_mux : 16'h0000;
      if (bus_rd_i || bus_wr_i) bus_hit_q <= addr_hit;
    end
  end

`ifdef DL11_RBUF_ERR_EN
  logic err_q, ovr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else if (rx_capture) begin
      if (done_q) begin
        err_q <= 1'b1;
        ovr_q <= 1'b1;
      end
    end else if (rbuf_rd) begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

  assign rbuf_err = err_q;
  assign rbuf_ovr = ovr_q;
`else
  assign rbuf_err = 1'b0;
  assign rbuf_ovr = 1'b0;
`endif

  assign bus_rdata_o  = bus_rdata_q;
  assign bus_hit_o    = bus_hit_q;
  assign rx_int_o     = done_q & rx_ie_q;
  assign tx_int_o     = ready_q & tx_ie_q;
  assign ld_tx_req_o  = ld_tx_req_q;
  assign uld_rx_req_o = uld_rx_req_q;
  assign tx_data_o    = tx_data_q;

endmodule

// File: tb/tb_dl11_host.sv
// Directed bench for dl11_host with behavioural uart rx/tx handshake responders.
module tb_dl11_host;

  localparam logic [12:0] Base = 13'o17560;
  localparam logic [12:0] ARcsr = Base + 13'd0;
  localparam logic [12:0] ARbuf = Base + 13'd2;
  localparam logic [12:0] AXcsr = Base + 13'd4;
  localparam logic [12:0] AXbuf = Base + 13'd6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] bus_addr = '0;
  logic        bus_rd = 1'b0, bus_wr = 1'b0;
  logic [15:0] bus_wdata = '0;
  logic [15:0] bus_rdata;
  logic        bus_hit, rx_int, tx_int, ld_tx_req, uld_rx_req;
  logic [7:0]  tx_data;
  logic        ld_tx_ack = 1'b0, tx_empty = 1'b1;
  logic        uld_rx_ack = 1'b0, rx_empty = 1'b1;
  logic [7:0]  rx_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dl11_host dut (
    .clk_i(clk), .rst_ni(rst_n), .bus_addr_i(bus_addr), .bus_rd_i(bus_rd), .bus_wr_i(bus_wr),
    .bus_wdata_i(bus_wdata), .bus_rdata_o(bus_rdata), .bus_hit_o(bus_hit), .rx_int_o(rx_int),
    .tx_int_o(tx_int), .ld_tx_req_o(ld_tx_req), .ld_tx_ack_i(ld_tx_ack), .tx_data_o(tx_data),
    .tx_empty_i(tx_empty), .uld_rx_req_o(uld_rx_req), .uld_rx_ack_i(uld_rx_ack),
    .rx_data_i(rx_data), .rx_empty_i(rx_empty)
  );

  // uart rx side: holds queued chars, acks 3 clocks after req, drops ack after rel delay
  logic [7:0] rx_fifo[$];
  int rx_phase = 0, rx_cnt = 0, rx_req_rises = 0, rx_acks = 0, rx_rel_delay = 0;
  always @(negedge clk) begin
    case (rx_phase)
      0: if (uld_rx_req && rx_fifo.size() != 0) begin
        rx_cnt = 0; rx_phase = 1; rx_req_rises++;
      end
      1: begin
        rx_cnt++;
        if (rx_cnt == 3) begin uld_rx_ack = 1'b1; rx_acks++; rx_phase = 2; end
      end
      2: if (!uld_rx_req) begin rx_cnt = 0; rx_phase = 3; end
      3: if (rx_cnt >= rx_rel_delay) begin
        uld_rx_ack = 1'b0; void'(rx_fifo.pop_front()); rx_phase = 0;
      end else rx_cnt++;
      default: rx_phase = 0;
    endcase
    rx_empty = (rx_fifo.size() == 0);
    if (rx_fifo.size() != 0) rx_data = rx_fifo[0];
  end

  // uart tx side: goes busy and acks 2 clocks after req, drains 5 clocks after ack falls
  int tx_phase = 0, tx_cnt = 0, tx_rises = 0, tx_unstable = 0;
  logic [7:0] tx_seen;
  always @(negedge clk) begin
    case (tx_phase)
      0: if (ld_tx_req) begin tx_rises++; tx_seen = tx_data; tx_cnt = 0; tx_phase = 1; end
      1: begin
        if (ld_tx_req && tx_data !== tx_seen) tx_unstable++;
        tx_cnt++;
        if (tx_cnt == 2) begin tx_empty = 1'b0; ld_tx_ack = 1'b1; tx_phase = 2; end
      end
      2: begin
        if (ld_tx_req && tx_data !== tx_seen) tx_unstable++;
        if (!ld_tx_req) begin ld_tx_ack = 1'b0; tx_cnt = 0; tx_phase = 3; end
      end
      3: begin
        tx_cnt++;
        if (tx_cnt == 5) begin tx_empty = 1'b1; tx_phase = 0; end
      end
      default: tx_phase = 0;
    endcase
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [12:0] a, output logic [15:0] d, output logic h);
    @(negedge clk);
    bus_addr = a; bus_rd = 1'b1;
    @(negedge clk);
    bus_rd = 1'b0;
    d = bus_rdata; h = bus_hit;
  endtask

  task automatic bus_write(input logic [12:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(negedge clk);
    bus_wr = 1'b0;
  endtask

  task automatic wait_rx_idle(input string name);
    int n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(rx_fifo.size() == 0 && rx_phase == 0 && !uld_rx_req) && n < 500);
    tests++;
    if (n >= 500) begin fails++; $display("FAIL %s: rx handshake still busy after %0d cycles", name, n); end
  endtask

  task automatic wait_tx_idle(input string name);
    int n = 0;
    do begin @(negedge clk); #1; n++; end
    while (!(tx_phase == 0 && tx_empty && !ld_tx_req) && n < 500);
    tests++;
    if (n >= 500) begin fails++; $display("FAIL %s: tx handshake still busy after %0d cycles", name, n); end
  endtask

  task automatic test_reset();
    logic [15:0] d; logic h;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    tests++; if ({bus_rdata, bus_hit, rx_int, tx_int, ld_tx_req, uld_rx_req, tx_data} !== 29'd0) begin
      fails++; $display("FAIL reset_outputs: got %h required 0",
        {bus_rdata, bus_hit, rx_int, tx_int, ld_tx_req, uld_rx_req, tx_data});
    end
    bus_read(ARcsr, d, h);
    tests++; if (d !== 16'h0000 || h !== 1'b1) begin fails++; $display("FAIL reset_rcsr: got %h hit %b required 0000 hit 1", d, h); end
    bus_read(ARbuf, d, h);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reset_rbuf: got %h required 0000", d); end
    bus_read(AXcsr, d, h);
    tests++; if (d !== 16'h0080) begin fails++; $display("FAIL reset_xcsr: got %h required 0080", d); end
  endtask

  task automatic test_rx();
    logic [15:0] d; logic h;
    rx_req_rises = 0;
    rx_fifo.push_back(8'h41);
    wait_rx_idle("rx_handshake");
    cycles(5);
    tests++; if (rx_req_rises !== 1 || uld_rx_req !== 1'b0) begin
      fails++; $display("FAIL rx_req_once: got %0d rises req=%b required 1 rises req=0", rx_req_rises, uld_rx_req);
    end
    bus_read(ARcsr, d, h);
    tests++; if (d !== 16'o200) begin fails++; $display("FAIL rx_rcsr_done: got %h required 0080", d); end
    tests++; if (rx_int !== 1'b0) begin fails++; $display("FAIL rx_int_masked: got %b required 0", rx_int); end
    bus_read(ARbuf, d, h);
    tests++; if (d !== 16'h0041) begin fails++; $display("FAIL rx_rbuf: got %h required 0041", d); end
    bus_read(ARcsr, d, h);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL rx_done_clear: got %h required 0000", d); end
  endtask

  task automatic test_tx();
    logic [15:0] d; logic h;
    tx_rises = 0; tx_unstable = 0;
    bus_write(ARcsr, 16'h0040);
    bus_write(AXcsr, 16'h0040);
    tests++; if (tx_int !== 1'b1 || rx_int !== 1'b0) begin
      fails++; $display("FAIL tx_ie_int: got tx_int=%b rx_int=%b required 1 0", tx_int, rx_int);
    end
    bus_write(AXbuf, 16'h0055);
    tests++; if (tx_int !== 1'b0 || ld_tx_req !== 1'b1 || tx_data !== 8'h55) begin
      fails++; $display("FAIL tx_start: got int=%b req=%b data=%h required 0 1 55", tx_int, ld_tx_req, tx_data);
    end
    wait_tx_idle("tx_handshake");
    cycles(5);
    tests++; if (tx_int !== 1'b1) begin fails++; $display("FAIL tx_int_return: got %b required 1", tx_int); end
    tests++; if (tx_unstable !== 0 || tx_rises !== 1) begin
      fails++; $display("FAIL tx_stable: got %0d unstable %0d rises required 0 1", tx_unstable, tx_rises);
    end
    bus_read(AXcsr, d, h);
    tests++; if (d !== 16'h00C0) begin fails++; $display("FAIL tx_xcsr_ready: got %h required 00c0", d); end
  endtask

  task automatic test_xbuf_busy();
    logic [15:0] d; logic h;
    tx_rises = 0;
    bus_write(AXbuf, 16'h0066);
    bus_write(AXbuf, 16'h0077);
    tests++; if (tx_data !== 8'h66) begin fails++; $display("FAIL busy_data: got %h required 66", tx_data); end
    wait_tx_idle("busy_handshake");
    cycles(5);
    tests++; if (tx_rises !== 1 || tx_data !== 8'h66) begin
      fails++; $display("FAIL busy_ignored: got %0d rises data %h required 1 66", tx_rises, tx_data);
    end
    bus_read(AXcsr, d, h);
    tests++; if (d !== 16'h00C0) begin fails++; $display("FAIL busy_xcsr: got %h required 00c0", d); end
  endtask

  task automatic test_overrun();
    logic [15:0] d, exp; logic h;
`ifdef DL11_RBUF_ERR_EN
    exp = 16'hC032;
`else
    exp = 16'h0032;
`endif
    rx_fifo.push_back(8'h31);
    rx_fifo.push_back(8'h32);
    wait_rx_idle("overrun_handshake");
    cycles(5);
    tests++; if (rx_int !== 1'b1) begin fails++; $display("FAIL ovr_rx_int: got %b required 1", rx_int); end
    bus_read(ARbuf, d, h);
    tests++; if (d !== exp) begin fails++; $display("FAIL ovr_rbuf: got %h required %h", d, exp); end
    bus_read(ARbuf, d, h);
    tests++; if (d !== 16'h0032) begin fails++; $display("FAIL ovr_clear: got %h required 0032", d); end
    bus_read(ARcsr, d, h);
    tests++; if (d !== 16'h0040 || rx_int !== 1'b0) begin
      fails++; $display("FAIL ovr_rcsr: got %h int %b required 0040 0", d, rx_int);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] d; logic h;
    int n = 0;
    rx_acks = 0; rx_rel_delay = 20;
    rx_fifo.push_back(8'h61);
    rx_fifo.push_back(8'h62);
    do begin @(negedge clk); #1; n++; end while (rx_phase != 3 && n < 200);
    tests++; if (n >= 200) begin fails++; $display("FAIL mid_rx_rel: timeout after %0d cycles", n); end
    bus_write(AXbuf, 16'h005A);
    tests++; if (ld_tx_req !== 1'b1) begin fails++; $display("FAIL mid_tx_req: got %b required 1", ld_tx_req); end
    rst_n = 1'b0;
    #1;
    tests++; if (ld_tx_req !== 1'b0 || uld_rx_req !== 1'b0) begin
      fails++; $display("FAIL mid_reqs_drop: got tx=%b rx=%b required 0 0", ld_tx_req, uld_rx_req);
    end
    cycles(2);
    rst_n = 1'b1;
    bus_read(ARcsr, d, h);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL mid_no_capture_a: got %h required 0000", d); end
    bus_read(AXcsr, d, h);
    tests++; if (d !== 16'h0080) begin fails++; $display("FAIL mid_ready: got %h required 0080", d); end
    cycles(2);
    bus_read(ARcsr, d, h);
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL mid_no_capture_b: got %h required 0000", d); end
    wait_rx_idle("mid_rx_finish");
    rx_rel_delay = 0;
    cycles(5);
    bus_read(ARbuf, d, h);
    tests++; if (d !== 16'h0062 || rx_acks !== 2) begin
      fails++; $display("FAIL mid_next_char: got %h acks %0d required 0062 2", d, rx_acks);
    end
    wait_tx_idle("mid_tx_finish");
  endtask

  task automatic test_unmapped();
    logic [15:0] d; logic h;
    bus_read(AXcsr, d, h);
    bus_read(Base + 13'd8, d, h);
    tests++; if (h !== 1'b0) begin fails++; $display("FAIL unmapped_hit: got %b required 0", h); end
    tests++; if (d !== 16'h0000) begin fails++; $display("FAIL unmapped_rdata: got %h required 0000", d); end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_xbuf_busy();
    test_overrun();
    test_reset_mid();
    test_unmapped();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
